// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared types and constants for the parity engine: parity
//                mode encoding, RX checker state encoding, minimum frame
//                length and the parity-bit selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

  // Parity mode as presented on PAR_MODE
  typedef enum logic [1:0] {
    PM_EVEN  = 2'b00,
    PM_ODD   = 2'b01,
    PM_MARK  = 2'b10,
    PM_SPACE = 2'b11
  } par_mode_e;

  // RX checker states
  typedef enum logic [1:0] {
    RX_IDLE   = 2'b00,
    RX_DATA   = 2'b01,
    RX_PARITY = 2'b10
  } rx_state_e;

  // Shortest frame honoured; anything shorter falls back to the full width
  localparam int MIN_LEN = 5;

  // Select the parity bit for a mode given the XOR of the active data bits
  function automatic logic parity_of(input par_mode_e mode, input logic data_xor);
    case (mode)
      PM_EVEN: return data_xor;
      PM_ODD:  return ~data_xor;
      PM_MARK: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : parity_rx_checker
//  Description : Serial RX parity checker. A start pulse latches the frame
//                configuration, data bits (LSB first) are accumulated into a
//                running parity, then an optional parity bit is compared and
//                a one-cycle done/error pulse is produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_rx_checker
  import parity_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             par_en,
  input  logic [1:0]       par_mode,
  input  logic [LEN_W-1:0] eff_len,
  input  logic             rx_start,
  input  logic             rx_bit_vld,
  input  logic             rx_bit,
  output logic             rx_done,
  output logic             par_err
);

  rx_state_e        state;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_q;
  logic             run_par;
  logic             en_q;
  par_mode_e        mode_q;

  // Frame FSM with registered done/error pulses; start always restarts a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      len_q   <= '0;
      run_par <= 1'b0;
      en_q    <= 1'b0;
      mode_q  <= PM_EVEN;
      rx_done <= 1'b0;
      par_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      par_err <= 1'b0;
      if (rx_start) begin
        en_q    <= par_en;
        mode_q  <= par_mode_e'(par_mode);
        len_q   <= eff_len;
        bit_cnt <= '0;
        run_par <= 1'b0;
        state   <= RX_DATA;
      end else begin
        case (state)
          RX_DATA: begin
            if (rx_bit_vld) begin
              run_par <= run_par ^ rx_bit;
              bit_cnt <= bit_cnt + LEN_W'(1);
              if (bit_cnt + LEN_W'(1) == len_q) begin
                if (en_q) begin
                  state <= RX_PARITY;
                end else begin
                  rx_done <= 1'b1;
                  state   <= RX_IDLE;
                end
              end
            end
          end
          RX_PARITY: begin
            if (rx_bit_vld) begin
              rx_done <= 1'b1;
              par_err <= (rx_bit != parity_of(mode_q, run_par));
              state   <= RX_IDLE;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parity_engine.sv
`default_nettype none
// ============================================================================
//  Module      : parity_engine
//  Description : Parity generator (TX) and serial parity checker (RX).
//                TX computes a parity bit over the active bits of a word on
//                acceptance; RX checks a serial frame in parity_rx_checker.
//                Optional macro PAR_ERR_CNT_EN adds a saturating 8-bit
//                parity-error counter with ERR_CNT_CLR / ERR_CNT ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_engine
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic [LEN_W-1:0]      DATA_LEN,
  input  logic                  BUSY,
  input  logic                  TX_VALID,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_READY,
  output logic                  TX_PAR_BIT,
  output logic                  TX_PAR_VLD,
  input  logic                  RX_START,
  input  logic                  RX_BIT_VLD,
  input  logic                  RX_BIT,
  output logic                  RX_DONE,
  output logic                  PAR_ERR
`ifdef PAR_ERR_CNT_EN
  ,
  input  logic                  ERR_CNT_CLR,
  output logic [7:0]            ERR_CNT
`endif
);

  logic                  accept;
  logic [LEN_W-1:0]      eff_len;
  logic [DATA_WIDTH-1:0] masked_data;

  // Ready follows BUSY directly, including while in reset
  assign TX_READY = ~BUSY;
  assign accept   = TX_VALID & TX_READY;

  // Out-of-range lengths fall back to the full data width
  always_comb begin
    if (int'(DATA_LEN) >= MIN_LEN && int'(DATA_LEN) <= DATA_WIDTH) begin
      eff_len = DATA_LEN;
    end else begin
      eff_len = LEN_W'(DATA_WIDTH);
    end
  end

  // Zero every data bit at or above the effective length
  always_comb begin
    masked_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      masked_data[i] = TX_DATA[i] & (i < int'(eff_len));
    end
  end

  // Capture the parity of an accepted job; the bit holds when parity is disabled
  always_ff @(posedge CLK) begin
    if (RST) begin
      TX_PAR_BIT <= 1'b0;
      TX_PAR_VLD <= 1'b0;
    end else begin
      TX_PAR_VLD <= 1'b0;
      if (accept && PAR_EN) begin
        TX_PAR_BIT <= parity_of(par_mode_e'(PAR_MODE), ^masked_data);
        TX_PAR_VLD <= 1'b1;
      end
    end
  end

  parity_rx_checker #(
    .LEN_W (LEN_W)
  ) u_rx (
    .clk        (CLK),
    .rst        (RST),
    .par_en     (PAR_EN),
    .par_mode   (PAR_MODE),
    .eff_len    (eff_len),
    .rx_start   (RX_START),
    .rx_bit_vld (RX_BIT_VLD),
    .rx_bit     (RX_BIT),
    .rx_done    (RX_DONE),
    .par_err    (PAR_ERR)
  );

`ifdef PAR_ERR_CNT_EN
  // Saturating error counter; clear takes priority over a coincident error
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_CNT <= 8'd0;
    end else if (ERR_CNT_CLR) begin
      ERR_CNT <= 8'd0;
    end else if (PAR_ERR && ERR_CNT != 8'hFF) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_engine
//  Description : Self-checking bench for parity_engine (DATA_WIDTH = 8).
//                Table-driven TX vectors, hand-written RX sequences and
//                randomized TX/RX traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [1:0] PAR_MODE = 2'd0;
  logic [3:0] DATA_LEN = 4'd8;
  logic       BUSY = 1'b0;
  logic       TX_VALID = 1'b0;
  logic [7:0] TX_DATA = 8'd0;
  logic       TX_READY, TX_PAR_BIT, TX_PAR_VLD;
  logic       RX_START = 1'b0;
  logic       RX_BIT_VLD = 1'b0;
  logic       RX_BIT = 1'b0;
  logic       RX_DONE, PAR_ERR;
  logic       ERR_CNT_CLR = 1'b0;
  logic [7:0] ERR_CNT;

  parity_engine dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_MODE   (PAR_MODE),
    .DATA_LEN   (DATA_LEN),
    .BUSY       (BUSY),
    .TX_VALID   (TX_VALID),
    .TX_DATA    (TX_DATA),
    .TX_READY   (TX_READY),
    .TX_PAR_BIT (TX_PAR_BIT),
    .TX_PAR_VLD (TX_PAR_VLD),
    .RX_START   (RX_START),
    .RX_BIT_VLD (RX_BIT_VLD),
    .RX_BIT     (RX_BIT),
    .RX_DONE    (RX_DONE),
    .PAR_ERR    (PAR_ERR)
`ifdef PAR_ERR_CNT_EN
    ,
    .ERR_CNT_CLR(ERR_CNT_CLR),
    .ERR_CNT    (ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic last_err = 1'b0;
  int err_model = 0;
  logic err_pend = 1'b0;

  typedef struct {
    logic       valid;
    logic       busy;
    logic       en;
    logic [1:0] mode;
    logic [3:0] len;
    logic [7:0] data;
    logic       exp_bit;
    logic       exp_vld;
  } tx_vec_t;

  tx_vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference parity straight from the mode rules and a popcount
  function automatic logic ref_par(input logic [1:0] mode, input int len, input logic [7:0] d);
    int eff;
    logic [7:0] m;
    int ones;
    eff = (len >= 5 && len <= 8) ? len : 8;
    m = 8'((1 << eff) - 1);
    ones = $countones(d & m);
    case (mode)
      2'd0:    return 1'((ones % 2) == 1);
      2'd1:    return 1'((ones % 2) == 0);
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int eff_of(input int len);
    return (len >= 5 && len <= 8) ? len : 8;
  endfunction

  // One clock; observes RX pulses and tracks the expected error count
  task automatic tick();
    @(posedge CLK);
    #1;
    if (RST) err_model = 0;
    else if (ERR_CNT_CLR) err_model = 0;
    else if (err_pend && err_model < 255) err_model++;
    err_pend = RX_DONE & PAR_ERR;
    if (RX_DONE) begin
      done_cnt++;
      last_err = PAR_ERR;
    end
  endtask

  task automatic rx_start_frame(input logic en, input logic [1:0] mode, input logic [3:0] len);
    PAR_EN = en; PAR_MODE = mode; DATA_LEN = len;
    RX_START = 1'b1;
    tick();
    RX_START = 1'b0;
  endtask

  task automatic rx_send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      RX_BIT_VLD = 1'b1;
      RX_BIT = bits[i];
      tick();
    end
    RX_BIT_VLD = 1'b0;
  endtask

  task automatic chk_err_cnt(input string name);
`ifdef PAR_ERR_CNT_EN
    chk(name, {24'd0, ERR_CNT}, err_model);
`endif
  endtask

  initial begin
    logic m_bit;
    logic m_vld;
    logic exp_p;
    logic flip;
    logic [1:0] md;
    logic [3:0] ln;
    logic [7:0] dt;
    logic en;
    int eff;

    tv[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'd8, 8'hA5, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 2'd1, 4'd8, 8'hA5, 1'b1, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 2'd0, 4'd8, 8'h01, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'd5, 8'hFF, 1'b1, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'd3, 8'hFF, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'd8, 8'h00, 1'b1, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'd8, 8'h00, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 4'd8, 8'h00, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 2'd3, 4'd8, 8'hFF, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'd9, 8'h80, 1'b1, 1'b1};
    tv[10] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'd6, 8'h60, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'd7, 8'hC0, 1'b1, 1'b1};

    // ---------------- reset state ----------------
    RST = 1'b1;
    tick(); tick();
    chk("rst_tx_ready", TX_READY, 1'b1);
    chk("rst_tx_par_bit", TX_PAR_BIT, 1'b0);
    chk("rst_tx_par_vld", TX_PAR_VLD, 1'b0);
    chk("rst_rx_done", RX_DONE, 1'b0);
    chk("rst_par_err", PAR_ERR, 1'b0);
    BUSY = 1'b1;
    #1;
    chk("rst_tx_ready_busy", TX_READY, 1'b0);
    BUSY = 1'b0;
    chk_err_cnt("rst_err_cnt");
    RST = 1'b0;
    tick();

    // ---------------- TX table ----------------
    for (int i = 0; i < 12; i++) begin
      TX_VALID = tv[i].valid; BUSY = tv[i].busy; PAR_EN = tv[i].en;
      PAR_MODE = tv[i].mode; DATA_LEN = tv[i].len; TX_DATA = tv[i].data;
      #1;
      chk($sformatf("tx_ready[%0d]", i), TX_READY, !tv[i].busy);
      tick();
      chk($sformatf("tx_bit[%0d]", i), TX_PAR_BIT, tv[i].exp_bit);
      chk($sformatf("tx_vld[%0d]", i), TX_PAR_VLD, tv[i].exp_vld);
      TX_VALID = 1'b0; BUSY = 1'b0;
      tick();
      chk($sformatf("tx_vld_drop[%0d]", i), TX_PAR_VLD, 1'b0);
      chk($sformatf("tx_bit_hold[%0d]", i), TX_PAR_BIT, tv[i].exp_bit);
    end

    // ---------------- TX random vs model ----------------
    RST = 1'b1; tick(); RST = 1'b0;
    m_bit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      TX_VALID = 1'($urandom % 2); BUSY = 1'(($urandom % 4) == 0);
      PAR_EN = 1'(($urandom % 4) != 0); PAR_MODE = 2'($urandom);
      DATA_LEN = 4'($urandom); TX_DATA = 8'($urandom);
      m_vld = TX_VALID && !BUSY && PAR_EN;
      if (m_vld) m_bit = ref_par(PAR_MODE, int'(DATA_LEN), TX_DATA);
      #1;
      chk("rnd_tx_ready", TX_READY, !BUSY);
      tick();
      chk("rnd_tx_bit", TX_PAR_BIT, m_bit);
      chk("rnd_tx_vld", TX_PAR_VLD, m_vld);
    end
    TX_VALID = 1'b0; BUSY = 1'b0;
    tick();

    // ---------------- RX: good and bad even parity on 8'h01 ----------------
    rx_start_frame(1'b1, 2'd0, 4'd8);
    done_cnt = 0;
    rx_send(16'h0001, 8);
    chk("rx_a_no_early_done", done_cnt, 0);
    rx_send(16'h0001, 1);
    chk("rx_a_done", RX_DONE, 1'b1);
    chk("rx_a_err", PAR_ERR, 1'b0);
    tick();
    chk("rx_a_done_pulse", RX_DONE, 1'b0);
    chk_err_cnt("err_cnt_before");

    rx_start_frame(1'b1, 2'd0, 4'd8);
    rx_send(16'h0001, 8);
    rx_send(16'h0000, 1);
    chk("rx_b_done", RX_DONE, 1'b1);
    chk("rx_b_err", PAR_ERR, 1'b1);
    tick();
    chk_err_cnt("err_cnt_after");

    // ---------------- RX: restart mid-frame, 7-bit mark ----------------
    rx_start_frame(1'b1, 2'd2, 4'd7);
    rx_send(16'h000F, 4);
    rx_start_frame(1'b1, 2'd2, 4'd7);
    done_cnt = 0;
    rx_send(16'h007F, 7);
    chk("rx_c_no_early_done", done_cnt, 0);
    rx_send(16'h0001, 1);
    tick();
    chk("rx_c_single_done", done_cnt, 1);
    chk("rx_c_err", last_err, 1'b0);

    // ---------------- RX: parity disabled ----------------
    rx_start_frame(1'b0, 2'd0, 4'd7);
    done_cnt = 0;
    rx_send(16'h007F, 6);
    chk("rx_d_no_early_done", done_cnt, 0);
    rx_send(16'h0001, 1);
    chk("rx_d_done", RX_DONE, 1'b1);
    chk("rx_d_err", PAR_ERR, 1'b0);
    tick();
    chk("rx_d_done_pulse", RX_DONE, 1'b0);

    // ---------------- RX: reset in PARITY state ----------------
    rx_start_frame(1'b1, 2'd0, 4'd8);
    rx_send(16'h00FF, 8);
    done_cnt = 0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rx_e_done", RX_DONE, 1'b0);
    chk("rx_e_err", PAR_ERR, 1'b0);
    chk("rx_e_tx_bit", TX_PAR_BIT, 1'b0);
    chk("rx_e_tx_vld", TX_PAR_VLD, 1'b0);
    rx_send(16'h0001, 1);
    tick();
    chk("rx_e_idle_ignores", done_cnt, 0);

    // ---------------- RX: start coincident with a bit ----------------
    PAR_EN = 1'b1; PAR_MODE = 2'd0; DATA_LEN = 4'd5;
    RX_START = 1'b1; RX_BIT_VLD = 1'b1; RX_BIT = 1'b1;
    tick();
    RX_START = 1'b0; RX_BIT_VLD = 1'b0;
    done_cnt = 0;
    rx_send(16'h0000, 5);
    chk("rx_f_no_early_done", done_cnt, 0);
    rx_send(16'h0000, 1);
    chk("rx_f_done", RX_DONE, 1'b1);
    chk("rx_f_err", PAR_ERR, 1'b0);

    // ---------------- RX random frames vs model ----------------
    for (int f = 0; f < 40; f++) begin
      en = 1'($urandom % 2); md = 2'($urandom); ln = 4'($urandom); dt = 8'($urandom);
      eff = eff_of(int'(ln));
      exp_p = ref_par(md, int'(ln), dt);
      flip = 1'(($urandom % 3) == 0);
      rx_start_frame(en, md, ln);
      done_cnt = 0;
      for (int b = 0; b < eff; b++) begin
        repeat ($urandom % 3) tick();
        rx_send({8'd0, dt} >> b, 1);
      end
      if (!en) begin
        chk("rnd_rx_done_nopar", RX_DONE, 1'b1);
        chk("rnd_rx_err_nopar", PAR_ERR, 1'b0);
      end else begin
        chk("rnd_rx_no_early_done", done_cnt, 0);
        repeat ($urandom % 3) tick();
        rx_send({15'd0, exp_p ^ flip}, 1);
        chk("rnd_rx_done", RX_DONE, 1'b1);
        chk("rnd_rx_err", PAR_ERR, flip);
      end
      tick();
    end
    chk_err_cnt("err_cnt_random");

    // ---------------- error counter clear ----------------
    ERR_CNT_CLR = 1'b1;
    tick();
    ERR_CNT_CLR = 1'b0;
    chk_err_cnt("err_cnt_clear");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parity_engine.md
PARITY_ENGINE -- requirements
Module: parity_engine

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, the maximum data bits per frame (legal 5..16).
REQ-002 The module SHALL have parameter LEN_W, default $clog2(DATA_WIDTH+1), the width of DATA_LEN.
REQ-003 The module SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port PAR_EN  input  1  parity enable, sampled at job start.
REQ-006 The module SHALL have port PAR_MODE  input  2  parity mode: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
REQ-007 The module SHALL have port DATA_LEN  input  LEN_W  active data bits per frame, sampled at job start.
REQ-008 The module SHALL have port BUSY  input  1  transmitter busy; blocks TX acceptance.
REQ-009 The module SHALL have the TX-side ports: TX_VALID input 1; TX_DATA input DATA_WIDTH; TX_READY output 1; TX_PAR_BIT output 1; TX_PAR_VLD output 1.
REQ-010 The module SHALL have the RX-side ports: RX_START input 1 (frame-start pulse); RX_BIT_VLD input 1; RX_BIT input 1 (serial bit, LSB first); RX_DONE output 1; PAR_ERR output 1.

Function
REQ-011 TX_READY SHALL be high exactly when BUSY is low; a TX job is accepted on a cycle with TX_VALID and TX_READY both high.
REQ-012 On acceptance, the module SHALL latch PAR_EN, PAR_MODE, DATA_LEN and TX_DATA; bits at index >= effective length SHALL be masked to 0.
REQ-013 The effective length SHALL be DATA_LEN when 5 <= DATA_LEN <= DATA_WIDTH, otherwise DATA_WIDTH.
REQ-014 TX_PAR_BIT SHALL update exactly one cycle after acceptance and SHALL hold until the next accepted job.
REQ-015 TX_PAR_BIT SHALL be XOR of masked data for even mode, its inverse for odd mode, 1 for mark mode and 0 for space mode.
REQ-016 TX_PAR_VLD SHALL pulse for that same single cycle only when the latched PAR_EN is 1; with PAR_EN 0, TX_PAR_BIT SHALL hold its previous value.
REQ-017 The RX checker SHALL be an FSM with states IDLE, DATA and PARITY.
REQ-018 RX_START SHALL latch the configuration, clear the bit counter and running parity, and enter DATA from any state, restarting a frame in progress.
REQ-019 In DATA, each RX_BIT_VLD SHALL XOR RX_BIT into the running parity and increment the counter; no change occurs without RX_BIT_VLD.
REQ-020 After the effective-length-th data bit, the FSM SHALL go to PARITY if PAR_EN was latched 1; otherwise it SHALL pulse RX_DONE (PAR_ERR=0) the next cycle and return to IDLE.
REQ-021 In PARITY, the next RX_BIT_VLD SHALL compare RX_BIT with the expected bit per REQ-015, pulse RX_DONE for one cycle, set PAR_ERR=1 in that cycle on mismatch, and return to IDLE.
REQ-022 RX_BIT_VLD in IDLE SHALL be ignored; if RX_START and RX_BIT_VLD coincide, RX_START wins and the bit is discarded.
REQ-023 TX and RX paths SHALL operate independently and concurrently.

Reset
REQ-024 While RST is high at a clock edge: FSM=IDLE, counter=0, TX_PAR_BIT=0, TX_PAR_VLD=0, RX_DONE=0, PAR_ERR=0, latched configuration and data=0; reset mid-frame SHALL abandon the frame with no RX_DONE.
REQ-025 TX_READY SHALL remain a combinational function of BUSY during reset.

Configuration
REQ-026 With macro PAR_ERR_CNT_EN defined, the module SHALL add input ERR_CNT_CLR (1) and output ERR_CNT (8), a counter that increments on each PAR_ERR pulse, saturates at 255, is cleared by ERR_CNT_CLR (clear wins over increment) and resets to 0.
REQ-027 Without PAR_ERR_CNT_EN, those ports and that logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package parity_pkg SHALL hold the PAR_MODE encoding typedef, the RX state typedef, and constant MIN_LEN=5.
REQ-029 The RX path SHALL be the sub-module parity_rx_checker; the TX path and the error counter SHALL stay in the top module.

Verification
REQ-030 Scenario: TX_DATA=8'hA5, DATA_LEN=8, even, BUSY=0 -> TX_PAR_BIT=0 and TX_PAR_VLD=1 one cycle after accept; repeat in odd mode -> 1.
REQ-031 Scenario: TX_DATA=8'hFF, DATA_LEN=5, even -> TX_PAR_BIT=1 (bits 7:5 masked); DATA_LEN=3 -> treated as 8 -> TX_PAR_BIT=0.
REQ-032 Scenario: BUSY=1 with TX_VALID=1 and new data -> TX_READY=0, TX_PAR_BIT and TX_PAR_VLD unchanged.
REQ-033 Scenario: RX frame 8'h01 + parity 1, even mode -> RX_DONE=1, PAR_ERR=0; the same frame with parity 0 -> PAR_ERR=1 and, with PAR_ERR_CNT_EN defined, ERR_CNT goes 0->1.
REQ-034 Scenario: RX_START after 4 data bits, then a full 7-bit frame 7'h7F with mark parity 1 -> a single RX_DONE with PAR_ERR=0; PAR_EN=0 -> RX_DONE one cycle after the 7th bit.
REQ-035 Scenario: RST asserted in PARITY state -> next cycle IDLE, all outputs 0, no RX_DONE.
